// File: rtl/gigatron_ram_arbiter_if.sv
// Purpose: bundles the CPU, video-fetch and RAM-side signals of the RAM arbiter.
// Latency: none; this only carries signals.
// Backpressure: requesters hold Req/addr/data until they see Gnt; no buffering here.
interface gigatron_ram_arbiter_if #(
  parameter int ADDR_W = 16
);
  // CPU requester
  logic              i_Cpu_Req;
  logic              i_Cpu_We;
  logic [ADDR_W-1:0] i_Cpu_Addr;
  logic [7:0]        i_Cpu_Wdata;
  logic              o_Cpu_Gnt;
  logic              o_Cpu_Rvalid;
  logic [7:0]        o_Cpu_Rdata;
  // Video scan-out fetcher (read-only)
  logic              i_Vid_Req;
  logic [ADDR_W-1:0] i_Vid_Addr;
  logic              o_Vid_Gnt;
  logic              o_Vid_Rvalid;
  logic [7:0]        o_Vid_Rdata;
  // Single-port RAM
  logic              o_Ram_We;
  logic [ADDR_W-1:0] o_Ram_Addr;
  logic [7:0]        o_Ram_Wdata;
  logic [7:0]        i_Ram_Rdata;

  // Arbiter side
  modport slave (
    input  i_Cpu_Req, i_Cpu_We, i_Cpu_Addr, i_Cpu_Wdata,
    input  i_Vid_Req, i_Vid_Addr, i_Ram_Rdata,
    output o_Cpu_Gnt, o_Cpu_Rvalid, o_Cpu_Rdata,
    output o_Vid_Gnt, o_Vid_Rvalid, o_Vid_Rdata,
    output o_Ram_We, o_Ram_Addr, o_Ram_Wdata
  );

  // Requester / RAM side
  modport master (
    output i_Cpu_Req, i_Cpu_We, i_Cpu_Addr, i_Cpu_Wdata,
    output i_Vid_Req, i_Vid_Addr, i_Ram_Rdata,
    input  o_Cpu_Gnt, o_Cpu_Rvalid, o_Cpu_Rdata,
    input  o_Vid_Gnt, o_Vid_Rvalid, o_Vid_Rdata,
    input  o_Ram_We, o_Ram_Addr, o_Ram_Wdata
  );
endinterface

// File: rtl/gigatron_ram_arbiter.sv
// Purpose: shares one single-port RAM between the CPU and the video fetcher, CPU first with a starvation guard.
// Latency: grant is combinational; read data valid exactly 1 cycle after a read grant, fully pipelined.
// Backpressure: a loser simply sees Gnt=0 and must hold its request; video is forced through after MAX_WAIT denials.
module gigatron_ram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 4,
  parameter int STALL_W  = 16
) (
  input  logic               i_Clk,
  input  logic               i_Reset_n,
  gigatron_ram_arbiter_if.slave bus,
  output logic [STALL_W-1:0] o_Vid_Stall_Count
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

  logic [7:0]         r_Wait_Cnt;
  logic               r_Boost;
  logic               r_Cpu_Rvalid;
  logic               r_Vid_Rvalid;
  logic [STALL_W-1:0] r_Stall_Cnt;

  logic               w_Cpu_Gnt;
  logic               w_Vid_Gnt;
  logic               w_Vid_Denied;
  logic               w_Ram_We;
  logic [ADDR_W-1:0]  w_Ram_Addr;
  logic [7:0]         w_Ram_Wdata;

  // Pick at most one winner; boost flips priority to video. Nothing is granted while in reset.
  always_comb begin
    w_Cpu_Gnt = 1'b0;
    w_Vid_Gnt = 1'b0;
    if (i_Reset_n) begin
      if (r_Boost) begin
        if (bus.i_Vid_Req)      w_Vid_Gnt = 1'b1;
        else if (bus.i_Cpu_Req) w_Cpu_Gnt = 1'b1;
      end else begin
        if (bus.i_Cpu_Req)      w_Cpu_Gnt = 1'b1;
        else if (bus.i_Vid_Req) w_Vid_Gnt = 1'b1;
      end
    end
  end

  assign w_Vid_Denied = bus.i_Vid_Req & ~w_Vid_Gnt;

  // Steer the winner onto the RAM port; an idle cycle drives all zeros.
  always_comb begin
    w_Ram_We    = 1'b0;
    w_Ram_Addr  = '0;
    w_Ram_Wdata = 8'h00;
    if (w_Cpu_Gnt) begin
      w_Ram_We    = bus.i_Cpu_We;
      w_Ram_Addr  = bus.i_Cpu_Addr;
      w_Ram_Wdata = bus.i_Cpu_Wdata;
    end else if (w_Vid_Gnt) begin
      w_Ram_Addr  = bus.i_Vid_Addr;
    end
  end

  // Starvation guard: count consecutive denials, raise boost on the edge that reaches MAX_WAIT.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Wait_Cnt <= 8'd0;
      r_Boost    <= 1'b0;
    end else if (w_Vid_Denied) begin
      if (r_Wait_Cnt >= MAX_WAIT_C - 8'd1) begin
        r_Wait_Cnt <= MAX_WAIT_C;
        r_Boost    <= 1'b1;
      end else begin
        r_Wait_Cnt <= r_Wait_Cnt + 8'd1;
      end
    end else begin
      r_Wait_Cnt <= 8'd0;
      r_Boost    <= 1'b0;
    end
  end

  // Read-return flags track the RAM's one-cycle registered read; writes never return data.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Cpu_Rvalid <= 1'b0;
      r_Vid_Rvalid <= 1'b0;
    end else begin
      r_Cpu_Rvalid <= w_Cpu_Gnt & ~bus.i_Cpu_We;
      r_Vid_Rvalid <= w_Vid_Gnt;
    end
  end

  // Saturating count of denied video-request cycles, cleared only by reset.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Stall_Cnt <= '0;
    end else if (w_Vid_Denied && (r_Stall_Cnt != {STALL_W{1'b1}})) begin
      r_Stall_Cnt <= r_Stall_Cnt + STALL_ONE;
    end
  end

  assign bus.o_Cpu_Gnt    = w_Cpu_Gnt;
  assign bus.o_Vid_Gnt    = w_Vid_Gnt;
  assign bus.o_Cpu_Rvalid = r_Cpu_Rvalid;
  assign bus.o_Vid_Rvalid = r_Vid_Rvalid;
  assign bus.o_Cpu_Rdata  = r_Cpu_Rvalid ? bus.i_Ram_Rdata : 8'h00;
  assign bus.o_Vid_Rdata  = r_Vid_Rvalid ? bus.i_Ram_Rdata : 8'h00;
  assign bus.o_Ram_We     = w_Ram_We;
  assign bus.o_Ram_Addr   = w_Ram_Addr;
  assign bus.o_Ram_Wdata  = w_Ram_Wdata;
  assign o_Vid_Stall_Count = r_Stall_Cnt;

endmodule

// File: tb/tb_gigatron_ram_arbiter.sv
// Purpose: directed bench for gigatron_ram_arbiter with a 1K x 8 read-old-on-write RAM model.
// Latency: checks grants in-cycle and Rvalid/Rdata one cycle after each read grant.
// Backpressure: exercises CPU priority, the video starvation guard and asynchronous reset.
module tb_gigatron_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] stall;
  logic [1:0]  stall2;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  mem [0:1023];
  logic [7:0]  vid_exp [0:3];

  gigatron_ram_arbiter_if #(.ADDR_W(16)) b ();
  gigatron_ram_arbiter_if #(.ADDR_W(16)) b2 ();

  gigatron_ram_arbiter #(.ADDR_W(16), .MAX_WAIT(4), .STALL_W(16)) u_dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .bus(b), .o_Vid_Stall_Count(stall)
  );

  // Second instance: MAX_WAIT=1 and a 2-bit stall counter so saturation is reachable.
  gigatron_ram_arbiter #(.ADDR_W(16), .MAX_WAIT(1), .STALL_W(2)) u_dut2 (
    .i_Clk(clk), .i_Reset_n(rst_n), .bus(b2), .o_Vid_Stall_Count(stall2)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, old data returned on a same-cycle write.
  always @(posedge clk) begin
    if (b.o_Ram_We) mem[b.o_Ram_Addr[9:0]] <= b.o_Ram_Wdata;
    b.i_Ram_Rdata <= mem[b.o_Ram_Addr[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;
    vid_exp[0] = 8'h11; vid_exp[1] = 8'h22; vid_exp[2] = 8'h33; vid_exp[3] = 8'h44;
    b.i_Ram_Rdata = 8'h00;
    b.i_Cpu_Req = 1'b0; b.i_Cpu_We = 1'b0; b.i_Cpu_Addr = 16'h0000; b.i_Cpu_Wdata = 8'h00;
    b.i_Vid_Req = 1'b0; b.i_Vid_Addr = 16'h0000;
    // Instance 2 sees both requesters asserting forever.
    b2.i_Ram_Rdata = 8'h00;
    b2.i_Cpu_Req = 1'b1; b2.i_Cpu_We = 1'b0; b2.i_Cpu_Addr = 16'h0000; b2.i_Cpu_Wdata = 8'h00;
    b2.i_Vid_Req = 1'b1; b2.i_Vid_Addr = 16'h0000;

    // --- Reset: grants forced off, state cleared ---
    next_cycle(); next_cycle();
    b.i_Cpu_Req = 1'b1; b.i_Cpu_Addr = 16'h0005;
    #1;
    chk("rst_cpu_gnt", b.o_Cpu_Gnt, 0);
    chk("rst_vid_gnt", b.o_Vid_Gnt, 0);
    chk("rst_cpu_rvalid", b.o_Cpu_Rvalid, 0);
    chk("rst_vid_rvalid", b.o_Vid_Rvalid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_ram_addr", b.o_Ram_Addr, 0);
    chk("rst2_vid_gnt", b2.o_Vid_Gnt, 0);

    // Release with a CPU read of 0x005 pending: granted in the same cycle.
    rst_n = 1'b1;
    #1;
    chk("rel_cpu_gnt", b.o_Cpu_Gnt, 1);
    chk("rel_ram_addr", b.o_Ram_Addr, 16'h0005);
    chk("rel_ram_we", b.o_Ram_We, 0);
    chk("rel_cpu_rdata", b.o_Cpu_Rdata, 8'h00);
    chk("rel2_cpu_gnt", b2.o_Cpu_Gnt, 1);
    chk("rel2_stall", stall2, 0);

    // --- CPU write 0xA5 to 0x123 ---
    next_cycle();
    chk("rd5_rvalid", b.o_Cpu_Rvalid, 1);
    chk("rd5_rdata", b.o_Cpu_Rdata, 8'h00);
    chk("b2_boost_vid_gnt", b2.o_Vid_Gnt, 1);
    chk("b2_boost_cpu_gnt", b2.o_Cpu_Gnt, 0);
    chk("b2_stall1", stall2, 1);
    b.i_Cpu_We = 1'b1; b.i_Cpu_Addr = 16'h0123; b.i_Cpu_Wdata = 8'hA5;
    #1;
    chk("wr_gnt", b.o_Cpu_Gnt, 1);
    chk("wr_ram_we", b.o_Ram_We, 1);
    chk("wr_ram_wdata", b.o_Ram_Wdata, 8'hA5);
    chk("wr_ram_addr", b.o_Ram_Addr, 16'h0123);

    // --- Read back 0x123 the cycle after the write ---
    next_cycle();
    chk("wr_no_rvalid", b.o_Cpu_Rvalid, 0);
    chk("b2_cpu_back", b2.o_Cpu_Gnt, 1);
    b.i_Cpu_We = 1'b0; b.i_Cpu_Wdata = 8'h00;
    #1;
    chk("rd123_gnt", b.o_Cpu_Gnt, 1);
    chk("rd123_ram_we", b.o_Ram_We, 0);

    // --- Contention: both request, CPU wins ---
    next_cycle();
    chk("rd123_rvalid", b.o_Cpu_Rvalid, 1);
    chk("rd123_rdata", b.o_Cpu_Rdata, 8'hA5);
    b.i_Cpu_Addr = 16'h0005; b.i_Vid_Req = 1'b1; b.i_Vid_Addr = 16'h0100;
    #1;
    chk("cont_cpu_gnt", b.o_Cpu_Gnt, 1);
    chk("cont_vid_gnt", b.o_Vid_Gnt, 0);
    chk("cont_stall_before", stall, 0);

    next_cycle();
    chk("cont_stall", stall, 1);
    chk("cont_cpu_rvalid", b.o_Cpu_Rvalid, 1);
    chk("cont_vid_rvalid", b.o_Vid_Rvalid, 0);
    // Idle cycle: no winner drives zeros, and the wait counter clears.
    b.i_Cpu_Req = 1'b0; b.i_Vid_Req = 1'b0;
    #1;
    chk("idle_ram_we", b.o_Ram_We, 0);
    chk("idle_ram_addr", b.o_Ram_Addr, 0);
    chk("idle_ram_wdata", b.o_Ram_Wdata, 0);

    // --- Starvation: both request for 10 cycles, video wins cycles 5 and 10 ---
    next_cycle();
    b.i_Cpu_Req = 1'b1; b.i_Cpu_We = 1'b0; b.i_Cpu_Addr = 16'h0005;
    b.i_Vid_Req = 1'b1; b.i_Vid_Addr = 16'h0100;
    #1;
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("starve_vid_gnt_%0d", k), b.o_Vid_Gnt, (k == 5 || k == 10) ? 1 : 0);
      chk($sformatf("starve_cpu_gnt_%0d", k), b.o_Cpu_Gnt, (k == 5 || k == 10) ? 0 : 1);
      chk($sformatf("starve_vid_rvalid_%0d", k), b.o_Vid_Rvalid, (k == 6) ? 1 : 0);
      if (k == 5) begin
        chk("starve_vid_ram_we", b.o_Ram_We, 0);
        chk("starve_vid_ram_addr", b.o_Ram_Addr, 16'h0100);
      end
      next_cycle();
    end
    // One denial carried over from the contention cycle plus eight here.
    chk("starve_stall", stall, 9);
    chk("starve_vid_rvalid_11", b.o_Vid_Rvalid, 1);
    chk("starve_vid_rdata_11", b.o_Vid_Rdata, 8'h11);
    chk("starve_cpu_rvalid_11", b.o_Cpu_Rvalid, 0);

    // --- Video streaming 0x100..0x103 with CPU idle ---
    b.i_Cpu_Req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b.i_Vid_Addr = 16'h0100 + 16'(i);
      #1;
      chk($sformatf("stream_gnt_%0d", i), b.o_Vid_Gnt, 1);
      chk($sformatf("stream_addr_%0d", i), b.o_Ram_Addr, 32'h100 + 32'(i));
      next_cycle();
      chk($sformatf("stream_rvalid_%0d", i), b.o_Vid_Rvalid, 1);
      chk($sformatf("stream_rdata_%0d", i), b.o_Vid_Rdata, vid_exp[i]);
    end
    b.i_Vid_Req = 1'b0;
    next_cycle();
    chk("stream_end_rvalid", b.o_Vid_Rvalid, 0);
    chk("stream_stall", stall, 9);

    // --- Async reset with a video read in flight ---
    b.i_Vid_Req = 1'b1; b.i_Vid_Addr = 16'h0101;
    #1;
    chk("ar_vid_gnt", b.o_Vid_Gnt, 1);
    next_cycle();
    chk("ar_vid_rvalid_pre", b.o_Vid_Rvalid, 1);
    chk("ar_vid_rdata_pre", b.o_Vid_Rdata, 8'h22);
    chk("ar_b2_sat_a", stall2, 3);
    b.i_Cpu_Req = 1'b1;
    next_cycle();
    chk("ar_b2_sat_b", stall2, 3);
    next_cycle();
    chk("ar_b2_sat_c", stall2, 3);
    chk("ar_stall_pre", stall, 11);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_vid_rvalid", b.o_Vid_Rvalid, 0);
    chk("ar_vid_rdata", b.o_Vid_Rdata, 0);
    chk("ar_stall", stall, 0);
    chk("ar_b2_stall", stall2, 0);
    chk("ar_cpu_gnt", b.o_Cpu_Gnt, 0);
    #1 rst_n = 1'b1;
    #1;
    chk("ar_rel_cpu_gnt", b.o_Cpu_Gnt, 1);

    // Rebuild boost after four denials, then reset must clear it without an edge.
    for (int j = 1; j <= 3; j++) begin
      next_cycle();
      chk($sformatf("ar_deny_cpu_gnt_%0d", j), b.o_Cpu_Gnt, 1);
    end
    next_cycle();
    chk("ar_boost_vid_gnt", b.o_Vid_Gnt, 1);
    chk("ar_boost_cpu_gnt", b.o_Cpu_Gnt, 0);
    chk("ar_boost_stall", stall, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("ar2_vid_gnt", b.o_Vid_Gnt, 0);
    chk("ar2_stall", stall, 0);
    #1 rst_n = 1'b1;
    #1;
    chk("ar2_boost_cleared_cpu", b.o_Cpu_Gnt, 1);
    chk("ar2_boost_cleared_vid", b.o_Vid_Gnt, 0);
    next_cycle();
    chk("ar2_no_vid_rvalid", b.o_Vid_Rvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
